// File: rtl/hazard_unit_sb_pkg.sv
// hazard_unit_sb_pkg: shared constants for the hazard/forwarding controller.
//   RFIDX_W_DEF : default register-index width
//   FWD_*       : forward-select encodings driven on forwardA/forwardB
//   lstate_t    : load-use stall FSM states
package hazard_unit_sb_pkg;

    localparam int RFIDX_W_DEF = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } lstate_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write bits for MDU results plus MDU occupancy.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, wr, set_idx   MDU launch, launch writes a register, its destination
//   done, clr_idx        MDU result written back, its destination
//   rs1, rs2, rd         read-port indices
//   busy_rs1/rs2/rd      pending bit of each read port
//   full                 MDU_MAX ops in flight
module hazard_scoreboard
    import hazard_unit_sb_pkg::*;
#(
    parameter int RFIDX_W = RFIDX_W_DEF,
    parameter int MDU_MAX = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               wr,
    input  logic [RFIDX_W-1:0] set_idx,
    input  logic               done,
    input  logic [RFIDX_W-1:0] clr_idx,
    input  logic [RFIDX_W-1:0] rs1,
    input  logic [RFIDX_W-1:0] rs2,
    input  logic [RFIDX_W-1:0] rd,
    output logic               busy_rs1,
    output logic               busy_rs2,
    output logic               busy_rd,
    output logic               full
);

    localparam int DEPTH = 2**RFIDX_W;

    logic [DEPTH-1:0] sb, sb_next;
    logic [2:0]       cnt;

    // Clear first so a same-cycle relaunch on the completing register keeps it pending.
    always_comb begin
        sb_next = sb;
        if (done) sb_next[clr_idx] = 1'b0;
        if (start && wr && set_idx != '0) sb_next[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb  <= '0;
            cnt <= '0;
        end else begin
            sb  <= sb_next;
            cnt <= cnt + 3'(start) - 3'(done);
        end
    end

    assign busy_rs1 = sb[rs1];
    assign busy_rs2 = sb[rs2];
    assign busy_rd  = sb[rd];
    assign full     = (cnt == 3'(MDU_MAX));

    a_no_start_full: assert property (@(posedge clk) disable iff (!rstn) !(start && full));
    a_no_done_empty: assert property (@(posedge clk) disable iff (!rstn) !(done && cnt == '0));

endmodule

// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: stall/flush/forward controller for the 5-stage pipeline.
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   validD, rs1D, rs2D, rdD            D-stage instruction and its indices
//   use_rs1D, use_rs2D, regwriteD, mduD D-stage operand use / write / MDU op
//   rs1E, rs2E, rdE                    E-stage indices
//   regwriteE, memreadE, mdu_startE    E writes rd / is a load / launches MDU op
//   redirectE                          taken branch/jump resolved in E
//   regwriteM, rdM, regwriteW, rdW     M/W writeback info for forwarding
//   mdu_done, mdu_rd                   MDU writeback and its destination
//   stallF, stallD, flushD, flushE     pipeline controls
//   forwardA, forwardB                 operand source select (00 RF, 10 M, 01 W)
//   stall_cnt                          saturating count of stallD cycles
module hazard_unit_sb
    import hazard_unit_sb_pkg::*;
#(
    parameter int RFIDX_W    = RFIDX_W_DEF,
    parameter int LOAD_STALL = 1,
    parameter int MDU_MAX    = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               validD,
    input  logic [RFIDX_W-1:0] rs1D,
    input  logic [RFIDX_W-1:0] rs2D,
    input  logic [RFIDX_W-1:0] rdD,
    input  logic               use_rs1D,
    input  logic               use_rs2D,
    input  logic               regwriteD,
    input  logic               mduD,
    input  logic [RFIDX_W-1:0] rs1E,
    input  logic [RFIDX_W-1:0] rs2E,
    input  logic [RFIDX_W-1:0] rdE,
    input  logic               regwriteE,
    input  logic               memreadE,
    input  logic               mdu_startE,
    input  logic               redirectE,
    input  logic               regwriteM,
    input  logic               regwriteW,
    input  logic [RFIDX_W-1:0] rdM,
    input  logic [RFIDX_W-1:0] rdW,
    input  logic               mdu_done,
    input  logic [RFIDX_W-1:0] mdu_rd,
    output logic               stallF,
    output logic               stallD,
    output logic               flushD,
    output logic               flushE,
    output logic [1:0]         forwardA,
    output logic [1:0]         forwardB,
    output logic [CNT_W-1:0]   stall_cnt
);

    lstate_t    state, state_next;
    logic [2:0] lcnt, lcnt_next;
    logic       busy_rs1, busy_rs2, busy_rd, mdu_full;
    logic       load_haz, load_stall, sb_stall, cap_stall, stall_any;
    logic       m_ok, w_ok;

    hazard_scoreboard #(
        .RFIDX_W (RFIDX_W),
        .MDU_MAX (MDU_MAX)
    ) u_sb (
        .clk      (clk),
        .rstn     (rstn),
        .start    (mdu_startE),
        .wr       (regwriteE),
        .set_idx  (rdE),
        .done     (mdu_done),
        .clr_idx  (mdu_rd),
        .rs1      (rs1D),
        .rs2      (rs2D),
        .rd       (rdD),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd),
        .full     (mdu_full)
    );

    assign load_haz  = memreadE & regwriteE & (rdE != '0) & validD &
                       ((use_rs1D & (rdE == rs1D)) | (use_rs2D & (rdE == rs2D)));
    // The rdD term holds a later writer behind a pending MDU result (WAW).
    assign sb_stall  = validD & ((use_rs1D & busy_rs1) | (use_rs2D & busy_rs2) | (regwriteD & busy_rd));
    assign cap_stall = validD & mduD & mdu_full;

    // The detecting cycle is the first bubble; LSTALL supplies the remaining LOAD_STALL-1.
    always_comb begin
        state_next = state;
        lcnt_next  = lcnt;
        load_stall = 1'b0;
        if (state == LSTALL) begin
            load_stall = 1'b1;
            if (lcnt == '0) state_next = IDLE;
            else lcnt_next = lcnt - 3'd1;
        end else if (load_haz) begin
            load_stall = 1'b1;
            if (LOAD_STALL > 1) begin
                state_next = LSTALL;
                lcnt_next  = 3'(LOAD_STALL - 2);
            end
        end
        // The D instruction is wrong-path on a redirect, so its pending load stall is dropped.
        if (redirectE) begin
            state_next = IDLE;
            lcnt_next  = '0;
        end
        stall_any = load_stall | sb_stall | cap_stall;
        // Outputs are held low while in reset, whatever the inputs are doing.
        stallF = rstn & ~redirectE & stall_any;
        stallD = rstn & ~redirectE & stall_any;
        flushE = rstn & (redirectE | stall_any);
        flushD = rstn & redirectE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            lcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            lcnt  <= lcnt_next;
            if (stallD && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign m_ok     = regwriteM & (rdM != '0);
    assign w_ok     = regwriteW & (rdW != '0);
    assign forwardA = !rstn ? FWD_RF : (m_ok && rdM == rs1E) ? FWD_M : (w_ok && rdW == rs1E) ? FWD_W : FWD_RF;
    assign forwardB = !rstn ? FWD_RF : (m_ok && rdM == rs2E) ? FWD_M : (w_ok && rdW == rs2E) ? FWD_W : FWD_RF;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb_hazard_unit_sb: table vectors, directed multi-cycle sequences and random stimulus vs a reference model.
module tb_hazard_unit_sb;

    localparam int RW   = 5;
    localparam int LS   = 2;
    localparam int MM   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic validD, use_rs1D, use_rs2D, regwriteD, mduD;
    logic [RW-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW, mdu_rd;
    logic regwriteE, memreadE, mdu_startE, redirectE, regwriteM, regwriteW, mdu_done;
    logic stallF, stallD, flushD, flushE;
    logic [1:0] forwardA, forwardB;
    logic [CW-1:0] stall_cnt;

    hazard_unit_sb #(.RFIDX_W(RW), .LOAD_STALL(LS), .MDU_MAX(MM), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .validD(validD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .use_rs1D(use_rs1D), .use_rs2D(use_rs2D), .regwriteD(regwriteD), .mduD(mduD),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regwriteE(regwriteE), .memreadE(memreadE),
        .mdu_startE(mdu_startE), .redirectE(redirectE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .rdM(rdM), .rdW(rdW), .mdu_done(mdu_done), .mdu_rd(mdu_rd), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .flushE(flushE), .forwardA(forwardA), .forwardB(forwardB), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bubbles still owed, pending-register set, ops in flight, stall count.
    int lrem;
    bit busy [32];
    int inflight;
    int scnt;
    int q[$];

    typedef struct {
        logic          rwm;
        logic [RW-1:0] rdm;
        logic          rww;
        logic [RW-1:0] rdw, r1, r2;
        logic [1:0]    ea, eb;
    } fv_t;
    fv_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic clear_in();
        validD = 0; use_rs1D = 0; use_rs2D = 0; regwriteD = 0; mduD = 0;
        rs1D = 0; rs2D = 0; rdD = 0; rs1E = 0; rs2E = 0; rdE = 0;
        regwriteE = 0; memreadE = 0; mdu_startE = 0; redirectE = 0;
        regwriteM = 0; regwriteW = 0; rdM = 0; rdW = 0; mdu_done = 0; mdu_rd = 0;
    endtask

    task automatic model_reset();
        lrem = 0;
        inflight = 0;
        scnt = 0;
        busy = '{default: 0};
        q.delete();
    endtask

    function automatic int fwd(input logic [RW-1:0] rs);
        if (regwriteM && rdM != 0 && rdM == rs) return 2;
        if (regwriteW && rdW != 0 && rdW == rs) return 1;
        return 0;
    endfunction

    function automatic bit model_haz();
        return memreadE && regwriteE && rdE != 0 && validD &&
               ((use_rs1D && rdE == rs1D) || (use_rs2D && rdE == rs2D));
    endfunction

    function automatic bit model_src();
        return lrem > 0 || model_haz() ||
               (validD && ((use_rs1D && busy[rs1D]) || (use_rs2D && busy[rs2D]) || (regwriteD && busy[rdD]))) ||
               (validD && mduD && inflight == MM);
    endfunction

    task automatic cmp_model();
        bit s;
        s = model_src();
        check("stallF", stallF, s && !redirectE);
        check("stallD", stallD, s && !redirectE);
        check("flushD", flushD, redirectE);
        check("flushE", flushE, s || redirectE);
        check("forwardA", forwardA, fwd(rs1E));
        check("forwardB", forwardB, fwd(rs2E));
        check("stall_cnt", stall_cnt, scnt);
    endtask

    task automatic model_update();
        bit s, h;
        s = model_src() && !redirectE;
        h = model_haz();
        if (redirectE) lrem = 0;
        else if (lrem > 0) lrem--;
        else if (h) lrem = LS - 1;
        if (mdu_done) busy[mdu_rd] = 0;
        if (mdu_startE && regwriteE && rdE != 0) busy[rdE] = 1;
        inflight += int'(mdu_startE) - int'(mdu_done);
        if (s && scnt < CMAX) scnt++;
    endtask

    task automatic cycle();
        @(negedge clk);
        cmp_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 0;
        #1;
        clear_in();
        model_reset();
        @(negedge clk);
        #2 rstn = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        model_reset();

        // Outputs must be low during reset even with hazard-provoking inputs.
        regwriteM = 1; rdM = 3; rs1E = 3; rs2E = 3; redirectE = 1;
        memreadE = 1; regwriteE = 1; rdE = 4; validD = 1; use_rs1D = 1; rs1D = 4;
        #2;
        check("rst_stallF", stallF, 0);
        check("rst_stallD", stallD, 0);
        check("rst_flushD", flushD, 0);
        check("rst_flushE", flushE, 0);
        check("rst_fwdA", forwardA, 0);
        check("rst_fwdB", forwardB, 0);
        check("rst_cnt", stall_cnt, 0);
        clear_in();
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;

        // Forwarding table: {regwriteM, rdM, regwriteW, rdW, rs1E, rs2E, expA, expB}
        tbl[0] = '{1'b1, 5'd3,  1'b1, 5'd3,  5'd3,  5'd3,  2'b10, 2'b10};
        tbl[1] = '{1'b0, 5'd3,  1'b1, 5'd3,  5'd3,  5'd3,  2'b01, 2'b01};
        tbl[2] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00};
        tbl[3] = '{1'b1, 5'd4,  1'b1, 5'd3,  5'd4,  5'd3,  2'b10, 2'b01};
        tbl[4] = '{1'b0, 5'd4,  1'b0, 5'd3,  5'd4,  5'd3,  2'b00, 2'b00};
        tbl[5] = '{1'b1, 5'd31, 1'b1, 5'd31, 5'd31, 5'd30, 2'b10, 2'b00};
        tbl[6] = '{1'b0, 5'd5,  1'b1, 5'd6,  5'd5,  5'd6,  2'b00, 2'b01};
        for (int i = 0; i < 7; i++) begin
            regwriteM = tbl[i].rwm; rdM = tbl[i].rdm; regwriteW = tbl[i].rww; rdW = tbl[i].rdw;
            rs1E = tbl[i].r1; rs2E = tbl[i].r2;
            #1;
            check($sformatf("fwd_tbl%0d_A", i), forwardA, tbl[i].ea);
            check($sformatf("fwd_tbl%0d_B", i), forwardB, tbl[i].eb);
        end
        clear_in();

        // Load-use on x5: exactly two stall cycles, then release.
        do_reset();
        memreadE = 1; regwriteE = 1; rdE = 5; validD = 1; use_rs1D = 1; rs1D = 5;
        #1 check("lu_c1_stallD", stallD, 1);
        check("lu_c1_flushE", flushE, 1);
        cycle();
        memreadE = 0; regwriteE = 0; rdE = 0; regwriteM = 1; rdM = 5;
        #1 check("lu_c2_stallF", stallF, 1);
        cycle();
        regwriteM = 0; regwriteW = 1; rdW = 5;
        #1 check("lu_c3_release", stallD, 0);
        check("lu_cnt", stall_cnt, 2);
        cycle();
        validD = 0; use_rs1D = 0; rs1E = 5;
        #1 check("lu_fwdW", forwardA, 2'b01);
        cycle();

        // MDU on x7: consumer stalls through the done cycle, released one cycle later.
        do_reset();
        mdu_startE = 1; regwriteE = 1; rdE = 7;
        cycle();
        clear_in(); validD = 1; use_rs1D = 1; rs1D = 7;
        repeat (4) begin
            #1 check("mdu_wait", stallD, 1);
            cycle();
        end
        mdu_done = 1; mdu_rd = 7;
        #1 check("mdu_done_cycle", stallD, 1);
        cycle();
        mdu_done = 0;
        #1 check("mdu_release", stallD, 0);
        cycle();
        clear_in(); mdu_startE = 1; regwriteE = 1; rdE = 7;
        cycle();
        mdu_done = 1; mdu_rd = 7;
        cycle();
        clear_in(); validD = 1; use_rs1D = 1; rs1D = 7;
        #1 check("sb_set_wins", stallD, 1);
        cycle();

        // Occupancy: full stalls an MDU op; start+done together leave the count alone.
        clear_in(); mdu_startE = 1;
        cycle();
        clear_in(); validD = 1; mduD = 1;
        #1 check("mdu_full", stallD, 1);
        cycle();
        mdu_done = 1; mdu_rd = 7;
        #1 check("mdu_full_done", stallD, 1);
        cycle();
        mdu_done = 1; mdu_rd = 0; mdu_startE = 1;
        #1 check("mdu_one", stallD, 0);
        cycle();
        mdu_done = 0; mdu_startE = 0;
        #1 check("mdu_cnt_same", stallD, 0);
        mdu_startE = 1;
        cycle();
        mdu_startE = 0;
        #1 check("mdu_full_again", stallD, 1);
        cycle();

        // Counter saturation at all-ones.
        do_reset();
        mdu_startE = 1; regwriteE = 1; rdE = 7;
        cycle();
        clear_in(); validD = 1; use_rs1D = 1; rs1D = 7;
        repeat (20) cycle();
        check("cnt_sat", stall_cnt, CMAX);

        // Redirect during LSTALL drops the load stall.
        do_reset();
        memreadE = 1; regwriteE = 1; rdE = 5; validD = 1; use_rs1D = 1; rs1D = 5;
        cycle();
        memreadE = 0; regwriteE = 0; rdE = 0; redirectE = 1;
        #1 check("redir_stallD", stallD, 0);
        check("redir_stallF", stallF, 0);
        check("redir_flushD", flushD, 1);
        check("redir_flushE", flushE, 1);
        cycle();
        redirectE = 0;
        #1 check("redir_idle", stallD, 0);
        check("redir_cnt", stall_cnt, 1);
        cycle();

        // Async reset mid-LSTALL with x9 pending.
        do_reset();
        mdu_startE = 1; regwriteE = 1; rdE = 9;
        cycle();
        clear_in(); memreadE = 1; regwriteE = 1; rdE = 5; validD = 1; use_rs1D = 1; rs1D = 5;
        cycle();
        memreadE = 0; regwriteE = 0; rdE = 0; use_rs2D = 1; rs2D = 9; regwriteM = 1; rdM = 1; rs1E = 1;
        #1 check("pre_rst_stall", stallD, 1);
        #1 rstn = 0;
        #1;
        check("arst_stallF", stallF, 0);
        check("arst_stallD", stallD, 0);
        check("arst_flushE", flushE, 0);
        check("arst_fwdA", forwardA, 0);
        check("arst_cnt", stall_cnt, 0);
        clear_in();
        model_reset();
        @(negedge clk);
        #2 rstn = 1;
        @(posedge clk);
        #1;
        validD = 1; use_rs1D = 1; rs1D = 9;
        #1 check("arst_sb_clear", stallD, 0);
        check("arst_cnt_after", stall_cnt, 0);
        cycle();
        cycle();

        // Random stimulus against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            validD    = 1'($urandom_range(0, 1));
            use_rs1D  = 1'($urandom_range(0, 1));
            use_rs2D  = 1'($urandom_range(0, 1));
            regwriteD = 1'($urandom_range(0, 1));
            mduD      = ($urandom_range(0, 3) == 0);
            rs1D = 5'($urandom_range(0, 7)); rs2D = 5'($urandom_range(0, 7)); rdD = 5'($urandom_range(0, 7));
            rs1E = 5'($urandom_range(0, 7)); rs2E = 5'($urandom_range(0, 7)); rdE = 5'($urandom_range(0, 7));
            regwriteE = 1'($urandom_range(0, 1));
            memreadE  = ($urandom_range(0, 2) == 0);
            redirectE = ($urandom_range(0, 11) == 0);
            regwriteM = 1'($urandom_range(0, 1)); rdM = 5'($urandom_range(0, 7));
            regwriteW = 1'($urandom_range(0, 1)); rdW = 5'($urandom_range(0, 7));
            mdu_done = 0;
            mdu_rd = 0;
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, q.size() - 1);
                mdu_done = 1;
                mdu_rd = 5'(q[k]);
                q.delete(k);
            end
            mdu_startE = (inflight < MM) && ($urandom_range(0, 3) == 0);
            if (mdu_startE) q.push_back(int'(rdE));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
